// File: rtl/game_ctrl_fsm.sv
// Game-flow controller: key-edge decode, frame-timed countdown, play gating, winner latch.
// Latency: state and registered outputs update one cycle after the qualifying input is sampled.
// Backpressure: none; every input is sampled each cycle and nothing is ever stalled.
//
// Ports:
//   Clk, Reset   - system clock, synchronous active-high reset
//   frame_tick   - one-cycle pulse per video frame (drives the countdown)
//   keycodes     - packed per-player keycodes, player i at [8i+7:8i]
//   game_over    - per-player top-out level flags
//   outputState  - current state code (HALTED 000, IDLE 001, PLAYING 010, COUNTDOWN 100, PAUSED 101)
//   running      - high only while PLAYING
//   clear_board  - one-cycle pulse asking the playfields to clear
//   countdown    - remaining countdown frames
//   winner, tie  - surviving players / all-topped-out flag, valid in HALTED
module game_ctrl_fsm #(
    parameter int         NUM_PLAYERS      = 2,
    parameter logic [7:0] START_KEY        = 8'h2C,
    parameter logic [7:0] PAUSE_KEY        = 8'h13,
    parameter int         COUNTDOWN_FRAMES = 180
) (
    input  logic                                   Clk,
    input  logic                                   Reset,
    input  logic                                   frame_tick,
    input  logic [8*NUM_PLAYERS-1:0]               keycodes,
    input  logic [NUM_PLAYERS-1:0]                 game_over,
    output logic [2:0]                             outputState,
    output logic                                   running,
    output logic                                   clear_board,
    output logic [$clog2(COUNTDOWN_FRAMES+1)-1:0]  countdown,
    output logic [NUM_PLAYERS-1:0]                 winner,
    output logic                                   tie
);

    localparam int            CW      = $clog2(COUNTDOWN_FRAMES + 1);
    localparam logic [CW-1:0] CD_LOAD = CW'(COUNTDOWN_FRAMES);
    localparam logic [CW-1:0] CD_ONE  = CW'(1);

    typedef enum logic [2:0] {
        HALTED    = 3'b000,
        IDLE      = 3'b001,
        PLAYING   = 3'b010,
        COUNTDOWN = 3'b100,
        PAUSED    = 3'b101
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [8*NUM_PLAYERS-1:0] prev_keys;
    logic [CW-1:0]            countdown_d;
    logic [NUM_PLAYERS-1:0]   winner_d;
    logic                     tie_d;
    logic                     clear_board_d;
    logic                     start_press;
    logic                     pause_press;

    // A key counts only on the cycle its code first appears, so a held key
    // produces a single event. Events from all players are merged.
    always_comb begin
        start_press = 1'b0;
        pause_press = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if ((keycodes[8*i +: 8] == START_KEY) && (prev_keys[8*i +: 8] != START_KEY))
                start_press = 1'b1;
            if ((keycodes[8*i +: 8] == PAUSE_KEY) && (prev_keys[8*i +: 8] != PAUSE_KEY))
                pause_press = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            prev_keys   <= '0;
            countdown   <= '0;
            winner      <= '0;
            tie         <= 1'b0;
            clear_board <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_keys   <= keycodes;
            countdown   <= countdown_d;
            winner      <= winner_d;
            tie         <= tie_d;
            clear_board <= clear_board_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        countdown_d   = countdown;
        winner_d      = winner;
        tie_d         = tie;
        clear_board_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_press) begin
                    state_d       = COUNTDOWN;
                    countdown_d   = CD_LOAD;
                    clear_board_d = 1'b1;
                end
            end

            // Decrement happens only while already in COUNTDOWN, so a tick on
            // the entry edge never eats into the freshly loaded value.
            COUNTDOWN: begin
                if (frame_tick) begin
                    if (countdown <= CD_ONE) begin
                        state_d     = PLAYING;
                        countdown_d = '0;
                    end else begin
                        countdown_d = countdown - CD_ONE;
                    end
                end
            end

            // Top-out beats a simultaneous pause press.
            PLAYING: begin
                if (|game_over) begin
                    state_d = HALTED;
                    if (&game_over) begin
                        winner_d = '0;
                        tie_d    = 1'b1;
                    end else begin
                        winner_d = ~game_over;
                        tie_d    = 1'b0;
                    end
                end else if (pause_press) begin
                    state_d = PAUSED;
                end
            end

            // Resuming goes through a fresh countdown but keeps the boards.
            PAUSED: begin
                if (pause_press) begin
                    state_d     = COUNTDOWN;
                    countdown_d = CD_LOAD;
                end
            end

            HALTED: begin
                if (start_press) begin
                    state_d       = COUNTDOWN;
                    countdown_d   = CD_LOAD;
                    clear_board_d = 1'b1;
                    winner_d      = '0;
                    tie_d         = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                countdown_d = '0;
                winner_d    = '0;
                tie_d       = 1'b0;
            end
        endcase
    end

    assign outputState = state_q;
    assign running     = (state_q == PLAYING);

endmodule

// File: tb/tb_game_ctrl_fsm.sv
module tb_game_ctrl_fsm;

    localparam int NP = 2;
    localparam int CF = 3;

    localparam int PH_HALT  = 0;
    localparam int PH_IDLE  = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_CD    = 4;
    localparam int PH_PAUSE = 5;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic [15:0] keycodes;
    logic [1:0]  game_over;
    logic [2:0]  outputState;
    logic        running;
    logic        clear_board;
    logic [1:0]  countdown;
    logic [1:0]  winner;
    logic        tie;

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;
    int pause_seen = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    game_ctrl_fsm #(
        .NUM_PLAYERS(NP),
        .START_KEY(8'h2C),
        .PAUSE_KEY(8'h13),
        .COUNTDOWN_FRAMES(CF)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_tick(frame_tick),
        .keycodes(keycodes),
        .game_over(game_over),
        .outputState(outputState),
        .running(running),
        .clear_board(clear_board),
        .countdown(countdown),
        .winner(winner),
        .tie(tie)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_ph;
    int         m_left;
    logic [1:0] m_win;
    logic       m_tie;
    logic       m_clr;
    logic [7:0] m_prev [NP];
    logic       m_sp;
    logic       m_pp;

    always_comb begin
        m_sp = 1'b0;
        m_pp = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (keycodes[8*i +: 8] == 8'h2C && m_prev[i] != 8'h2C) m_sp = 1'b1;
            if (keycodes[8*i +: 8] == 8'h13 && m_prev[i] != 8'h13) m_pp = 1'b1;
        end
    end

    always @(posedge Clk) begin
        m_clr <= 1'b0;
        for (int i = 0; i < NP; i++)
            m_prev[i] <= Reset ? 8'h00 : keycodes[8*i +: 8];
        if (Reset) begin
            m_ph   <= PH_IDLE;
            m_left <= 0;
            m_win  <= 2'b00;
            m_tie  <= 1'b0;
        end else begin
            case (m_ph)
                PH_IDLE: if (m_sp) begin
                    m_ph <= PH_CD; m_left <= CF; m_clr <= 1'b1;
                end
                PH_CD: if (frame_tick) begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_ph <= PH_PLAY;
                end
                PH_PLAY: if (game_over != 2'b00) begin
                    // survivors are the players not topped out; none left means a tie
                    m_ph  <= PH_HALT;
                    m_win <= ~game_over;
                    m_tie <= &game_over;
                end else if (m_pp) begin
                    m_ph <= PH_PAUSE;
                end
                PH_PAUSE: if (m_pp) begin
                    m_ph <= PH_CD; m_left <= CF;
                end
                PH_HALT: if (m_sp) begin
                    m_ph <= PH_CD; m_left <= CF; m_clr <= 1'b1;
                    m_win <= 2'b00; m_tie <= 1'b0;
                end
                default: m_ph <= PH_IDLE;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("state", {29'd0, outputState}, m_ph);
            chk("running", {31'd0, running}, {31'd0, m_ph == PH_PLAY});
            chk("clear_board", {31'd0, clear_board}, {31'd0, m_clr});
            chk("countdown", {30'd0, countdown}, m_left);
            chk("winner", {30'd0, winner}, {30'd0, m_win});
            chk("tie", {31'd0, tie}, {31'd0, m_tie});
            if (clear_board) clr_cnt++;
            if (outputState == 3'b101) pause_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic peek();
        @(negedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
    endtask

    initial begin
        Reset      = 1'b1;
        keycodes   = 16'h0000;
        game_over  = 2'b00;
        frame_tick = 1'b0;
        step(2);
        chk_en = 1'b1;
        Reset  = 1'b0;

        // reset state
        peek();
        chk("rst_state", {29'd0, outputState}, 32'd1);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_countdown", {30'd0, countdown}, 32'd0);
        chk("rst_winner", {30'd0, winner}, 32'd0);
        chk("rst_tie", {31'd0, tie}, 32'd0);
        chk("rst_clear", {31'd0, clear_board}, 32'd0);

        // start held for 10 cycles on player 1
        clr_cnt = 0;
        keycodes[7:0] = 8'h2C;
        step(1);
        peek();
        chk("start_state", {29'd0, outputState}, 32'd4);
        chk("start_cd", {30'd0, countdown}, 32'd3);
        chk("start_clear", {31'd0, clear_board}, 32'd1);
        step(9);
        keycodes = 16'h0000;
        peek();
        chk("start_clr_once", clr_cnt, 32'd1);
        chk("start_hold_state", {29'd0, outputState}, 32'd4);

        tick();
        peek();
        chk("cd_after1", {30'd0, countdown}, 32'd2);
        tick();
        tick();
        peek();
        chk("play_state", {29'd0, outputState}, 32'd2);
        chk("play_running", {31'd0, running}, 32'd1);
        chk("play_cd", {30'd0, countdown}, 32'd0);

        // held pause key on player 1 for 50 cycles; game_over and ticks ignored while paused
        clr_cnt = 0;
        keycodes[7:0] = 8'h13;
        step(1);
        peek();
        chk("pause_state", {29'd0, outputState}, 32'd5);
        step(20);
        game_over = 2'b01;
        step(1);
        game_over = 2'b00;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(27);
        peek();
        chk("pause_hold_state", {29'd0, outputState}, 32'd5);
        chk("pause_hold_cd", {30'd0, countdown}, 32'd0);

        // release, press again with a tick on the entry edge
        keycodes = 16'h0000;
        step(2);
        keycodes[7:0] = 8'h13;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        keycodes = 16'h0000;
        peek();
        chk("resume_state", {29'd0, outputState}, 32'd4);
        chk("resume_cd_full", {30'd0, countdown}, 32'd3);

        // keys and game_over ignored during countdown
        game_over = 2'b11;
        keycodes[15:8] = 8'h2C;
        step(1);
        game_over = 2'b00;
        keycodes = 16'h0000;
        peek();
        chk("cd_ignore_state", {29'd0, outputState}, 32'd4);
        tick();
        tick();
        tick();
        peek();
        chk("resume_play", {29'd0, outputState}, 32'd2);
        chk("resume_no_clear", clr_cnt, 32'd0);

        // winner latch
        game_over = 2'b01;
        step(1);
        peek();
        chk("win_state", {29'd0, outputState}, 32'd0);
        chk("win_winner", {30'd0, winner}, 32'd2);
        chk("win_tie", {31'd0, tie}, 32'd0);
        game_over = 2'b11;
        step(3);
        game_over = 2'b00;
        keycodes[7:0] = 8'h13;
        step(3);
        keycodes = 16'h0000;
        peek();
        chk("win_hold_winner", {30'd0, winner}, 32'd2);
        chk("win_hold_tie", {31'd0, tie}, 32'd0);
        chk("win_hold_state", {29'd0, outputState}, 32'd0);

        // restart from player 2
        clr_cnt = 0;
        keycodes[15:8] = 8'h2C;
        step(1);
        peek();
        chk("restart_state", {29'd0, outputState}, 32'd4);
        chk("restart_clear", {31'd0, clear_board}, 32'd1);
        chk("restart_winner", {30'd0, winner}, 32'd0);
        chk("restart_tie", {31'd0, tie}, 32'd0);
        chk("restart_cd", {30'd0, countdown}, 32'd3);
        keycodes = 16'h0000;
        tick();
        tick();
        tick();
        peek();
        chk("restart_play", {29'd0, outputState}, 32'd2);
        chk("restart_clr_once", clr_cnt, 32'd1);

        // tie with simultaneous pause press on player 2
        pause_seen = 0;
        game_over = 2'b11;
        keycodes[15:8] = 8'h13;
        step(1);
        peek();
        chk("tie_state", {29'd0, outputState}, 32'd0);
        chk("tie_winner", {30'd0, winner}, 32'd0);
        chk("tie_flag", {31'd0, tie}, 32'd1);
        step(5);
        game_over = 2'b00;
        keycodes = 16'h0000;
        step(2);
        peek();
        chk("tie_no_pause", pause_seen, 32'd0);
        chk("tie_hold", {31'd0, tie}, 32'd1);

        // restart then reset during countdown
        keycodes[7:0] = 8'h2C;
        step(1);
        keycodes = 16'h0000;
        tick();
        peek();
        chk("pre_reset_cd", {30'd0, countdown}, 32'd2);
        clr_cnt = 0;
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        peek();
        chk("mid_reset_state", {29'd0, outputState}, 32'd1);
        chk("mid_reset_cd", {30'd0, countdown}, 32'd0);
        chk("mid_reset_clear", {31'd0, clear_board}, 32'd0);
        step(3);
        peek();
        chk("mid_reset_no_pulse", clr_cnt, 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Top-level game-flow controller for the N-player Tetris build.
- Decodes per-player PS/2 keycodes into start/pause events, runs a frame-timed pre-game countdown, and gates play.
- Latches the winner when any player's board tops out, and allows restart from game-over without a board reset.
- Drives `outputState` to the renderer, playfield and drop logic.

Parameters:
- `NUM_PLAYERS`, 2, number of player channels (1..4).
- `START_KEY`, 8'h2C, keycode that starts or restarts a game.
- `PAUSE_KEY`, 8'h13, keycode that toggles pause.
- `COUNTDOWN_FRAMES`, 180, frame ticks spent in countdown (must be >= 1).

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `keycodes`  in  8*NUM_PLAYERS  packed keycodes; player i occupies [8i+7:8i].
- `game_over`  in  NUM_PLAYERS  per-player top-out flag (level).
- `outputState`  out  3  current state code.
- `running`  out  1  high only in PLAYING.
- `clear_board`  out  1  one-cycle pulse telling the playfields to clear.
- `countdown`  out  $clog2(COUNTDOWN_FRAMES+1)  remaining countdown frames.
- `winner`  out  NUM_PLAYERS  one-hot or multi-hot surviving players, valid in HALTED.
- `tie`  out  1  all players topped out in the same cycle.

Behaviour:
- Clock and reset: Reset is synchronous and active-high; clock is Clk. All state is updated on the posedge of Clk.
- Reset values:
  - state = IDLE (outputState 3'b001).
  - running, clear_board, tie = 0; winner = 0; countdown = 0.
  - All previous-keycode registers = 8'h00.
- Output timing: outputState and running are decoded combinationally from the state register. A transition is visible in the cycle after the qualifying input is sampled.
- State codes:
  - HALTED = 000
  - IDLE = 001
  - PLAYING = 010
  - COUNTDOWN = 100
  - PAUSED = 101
  - 011, 110 and 111 are unused; an illegal state recovers to IDLE on the next edge.
- Key events: press_X[i] = (keycode_i == X) && (prev_i != X), where prev_i is keycode_i registered one cycle earlier.
  - A held key generates exactly one event.
  - Events from all players are ORed.
- IDLE:
  - start press -> COUNTDOWN; clear_board pulses for that edge's following cycle; countdown loads COUNTDOWN_FRAMES.
  - All other inputs are ignored.
- COUNTDOWN:
  - Each frame_tick decrements countdown.
  - A frame_tick while countdown == 1 -> PLAYING, with countdown = 0.
  - Keys and game_over are ignored.
- PLAYING:
  - If any game_over bit is set -> HALTED.
    - If at least one player survives, latch winner = ~game_over and tie = 0.
    - If every bit is set, latch winner = 0 and tie = 1.
  - Else a pause press -> PAUSED.
  - game_over has priority over a pause press in the same cycle.
- PAUSED:
  - game_over is ignored (boards are frozen).
  - A pause press -> COUNTDOWN; countdown reloads COUNTDOWN_FRAMES; clear_board is NOT pulsed.
- HALTED:
  - winner and tie hold.
  - A start press -> COUNTDOWN; clear_board pulses; winner and tie clear to 0; countdown reloads.
- frame_tick on the same edge as a state entry does not decrement the freshly loaded countdown.
- Reset mid-game: IDLE next cycle; no clear_board pulse is generated.

Test Plan:
- Test configuration: NUM_PLAYERS=2, COUNTDOWN_FRAMES=3.
- Start and countdown: Reset, then keycodes[7:0]=8'h2C held for 10 cycles.
  - Required: exactly one clear_board pulse; outputState 001 -> 100; countdown 3.
  - Required: after 3 frame_ticks, outputState=010, running=1, countdown=0.
- Held-key edge detect: hold 8'h13 on player 1 for 50 cycles while PLAYING.
  - Required: a single transition to 101; no toggle back.
  - Releasing and pressing again gives 100, then 010 after 3 ticks, with no clear_board pulse.
- Winner latch: in PLAYING, assert game_over=2'b01.
  - Required: outputState=000, winner=2'b10, tie=0; both values hold while game_over later changes.
- Tie and priority: in PLAYING, assert game_over=2'b11 together with a pause press on player 2.
  - Required: outputState=000, winner=2'b00, tie=1; PAUSED is never entered.
- Restart and reset: in HALTED, press 8'h2C on player 2.
  - Required: clear_board pulse, winner=0, tie=0, outputState=100.
  - Asserting Reset during COUNTDOWN gives outputState=001, countdown=0 on the next cycle.
